// File: rtl/fejkon_pcie_pkg.sv
// Shared PCIe completion definitions: FSM states, CplD header constants
// and the bit layout of the packed memory-access response word.
package fejkon_pcie_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    PAD_DATA
  } cpl_state_e;

  localparam logic [2:0]  CPLD_FMT      = 3'b010;
  localparam logic [4:0]  CPLD_TYPE     = 5'b01010;
  localparam logic [9:0]  CPLD_LEN      = 10'd1;
  localparam logic [11:0] CPLD_BYTE_CNT = 12'd4;
  localparam logic [31:0] CPLD_DW0      =
    {CPLD_FMT, CPLD_TYPE, 14'h0, CPLD_LEN};

  localparam int RESP_REQID_LSB = 0;
  localparam int RESP_TAG_LSB   = 16;
  localparam int RESP_LADDR_LSB = 24;
  localparam int RESP_DATA_LSB  = 32;

endpackage

// File: rtl/fejkon_pcie_cpl_gen_if.sv
// Bundle of the response-in and Avalon-ST TLP-out signals of the
// completion generator.
interface fejkon_pcie_cpl_gen_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [15:0]            completer_id;
  logic [127:0]           resp_data;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [63:0]            tx_st_data;
  logic                   tx_st_valid;
  logic                   tx_st_sop;
  logic                   tx_st_eop;
  logic                   tx_st_ready;
  logic [COUNT_WIDTH-1:0] cpl_count;

  modport master (
    input  completer_id, resp_data, resp_valid, tx_st_ready,
    output resp_ready, tx_st_data, tx_st_valid, tx_st_sop,
    output tx_st_eop, cpl_count
  );

  modport slave (
    output completer_id, resp_data, resp_valid, tx_st_ready,
    input  resp_ready, tx_st_data, tx_st_valid, tx_st_sop,
    input  tx_st_eop, cpl_count
  );
endinterface

// File: rtl/fejkon_pcie_cpl_gen.sv
// Turns one memory-read response into a single-DW CplD TLP on a 64-bit
// Avalon-ST source, padding the data DW when it lands qword-aligned.
module fejkon_pcie_cpl_gen
  import fejkon_pcie_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            completer_id,
  input  logic [127:0]           mem_access_resp_data,
  input  logic                   mem_access_resp_valid,
  output logic                   mem_access_resp_ready,
  output logic [63:0]            tx_st_data,
  output logic                   tx_st_valid,
  output logic                   tx_st_sop,
  output logic                   tx_st_eop,
  input  logic                   tx_st_ready,
  output logic [COUNT_WIDTH-1:0] cpl_count
);

  cpl_state_e state_q, state_d;
  logic [15:0] cid_q, cid_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [4:0]  la_q, la_d;
  logic [31:0] dat_q, dat_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        rdy;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic        unused_resp;

  assign unused_resp = ^{mem_access_resp_data[127:64],
                         mem_access_resp_data[31:29]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cid_q   <= '0;
      rid_q   <= '0;
      tag_q   <= '0;
      la_q    <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cid_q   <= cid_d;
      rid_q   <= rid_d;
      tag_q   <= tag_d;
      la_q    <= la_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cid_d       = cid_q;
    rid_d       = rid_q;
    tag_d       = tag_q;
    la_d        = la_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    rdy         = 1'b0;
    tx_st_valid = 1'b0;
    tx_st_sop   = 1'b0;
    tx_st_eop   = 1'b0;
    tx_st_data  = '0;
    dw1 = {cid_q, 3'b000, 1'b0, CPLD_BYTE_CNT};
    dw2 = {rid_q, tag_q, 1'b0, la_q, 2'b00};
    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (mem_access_resp_valid) begin
          cid_d   = completer_id;
          rid_d   = mem_access_resp_data[RESP_REQID_LSB +: 16];
          tag_d   = mem_access_resp_data[RESP_TAG_LSB +: 8];
          la_d    = mem_access_resp_data[RESP_LADDR_LSB +: 5];
          dat_d   = mem_access_resp_data[RESP_DATA_LSB +: 32];
          state_d = HDR0;
        end
      end
      HDR0: begin
        tx_st_valid = 1'b1;
        tx_st_sop   = 1'b1;
        tx_st_data  = {dw1, CPLD_DW0};
        if (tx_st_ready) state_d = HDR1;
      end
      HDR1: begin
        tx_st_valid = 1'b1;
        // Address bit 2 set: data shares the qword with DW2, no pad needed
        if (la_q[0]) begin
          tx_st_eop  = 1'b1;
          tx_st_data = {dat_q, dw2};
          if (tx_st_ready) begin
            state_d = IDLE;
            cnt_d   = cnt_q + COUNT_WIDTH'(1);
          end
        end else begin
          tx_st_data = {32'h0, dw2};
          if (tx_st_ready) state_d = PAD_DATA;
        end
      end
      PAD_DATA: begin
        tx_st_valid = 1'b1;
        tx_st_eop   = 1'b1;
        tx_st_data  = {32'h0, dat_q};
        if (tx_st_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_access_resp_ready = rdy & ~reset;
  assign cpl_count             = cnt_q;

endmodule

// File: tb/tb_fejkon_pcie_cpl_gen.sv
// Directed bench for the CplD generator: beat contents, latency,
// backpressure, back-to-back, reset mid-packet and counter wrap.
module tb_fejkon_pcie_cpl_gen;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fejkon_pcie_cpl_gen_if #(.COUNT_WIDTH(32)) bus ();

  logic        rr2, v2, s2, e2;
  logic [63:0] d2;
  logic [1:0]  cnt2;

  fejkon_pcie_cpl_gen #(.COUNT_WIDTH(32)) dut (
    .clk                   (clk),
    .reset                 (rst),
    .completer_id          (bus.completer_id),
    .mem_access_resp_data  (bus.resp_data),
    .mem_access_resp_valid (bus.resp_valid),
    .mem_access_resp_ready (bus.resp_ready),
    .tx_st_data            (bus.tx_st_data),
    .tx_st_valid           (bus.tx_st_valid),
    .tx_st_sop             (bus.tx_st_sop),
    .tx_st_eop             (bus.tx_st_eop),
    .tx_st_ready           (bus.tx_st_ready),
    .cpl_count             (bus.cpl_count)
  );

  fejkon_pcie_cpl_gen #(.COUNT_WIDTH(2)) dut_w (
    .clk                   (clk),
    .reset                 (rst),
    .completer_id          (bus.completer_id),
    .mem_access_resp_data  (bus.resp_data),
    .mem_access_resp_valid (bus.resp_valid),
    .mem_access_resp_ready (rr2),
    .tx_st_data            (d2),
    .tx_st_valid           (v2),
    .tx_st_sop             (s2),
    .tx_st_eop             (e2),
    .tx_st_ready           (bus.tx_st_ready),
    .cpl_count             (cnt2)
  );

  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    eops  = 0;
  int    acc_cyc[$];
  beat_t beats[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.resp_valid && bus.resp_ready)
        acc_cyc.push_back(cyc);
      if (bus.tx_st_valid && bus.tx_st_ready) begin
        beats.push_back('{bus.tx_st_data, bus.tx_st_sop,
                          bus.tx_st_eop, cyc});
        if (bus.tx_st_eop) eops++;
      end
    end
    cyc++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx,
                          input logic [63:0] d,
                          input logic [1:0] se);
    beat_t b;
    b = '{64'h0, 1'b0, 1'b0, 0};
    if (idx < beats.size()) b = beats[idx];
    check({tag, "_data"}, b.d, d);
    check({tag, "_sopeop"}, {62'h0, b.sop, b.eop}, {62'h0, se});
  endtask

  function automatic logic [127:0] pack(input logic [15:0] rid,
                                        input logic [7:0] tag,
                                        input logic [4:0] la,
                                        input logic [31:0] dat);
    return {64'hA5A5_5A5A_F0F0_0F0F, dat, 3'b111, la, tag, rid};
  endfunction

  task automatic send(input logic [15:0] rid, input logic [7:0] tag,
                      input logic [4:0] la, input logic [31:0] dat);
    int n0;
    n0 = acc_cyc.size();
    @(negedge clk);
    bus.resp_data  = pack(rid, tag, la, dat);
    bus.resp_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cyc.size() == n0; i++)
      @(negedge clk);
    bus.resp_valid = 1'b0;
    check("accept", acc_cyc.size(), n0 + 1);
  endtask

  task automatic wait_eops(input int target);
    for (int i = 0; i < 100 && eops < target; i++)
      @(negedge clk);
    check("eop_wait", eops, target);
  endtask

  int b0;
  int bs;
  int es;

  initial begin
    rst              = 1'b1;
    bus.completer_id = 16'h0100;
    bus.resp_data    = '0;
    bus.resp_valid   = 1'b0;
    bus.tx_st_ready  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", bus.tx_st_valid, 0);
    check("rst_sop", bus.tx_st_sop, 0);
    check("rst_eop", bus.tx_st_eop, 0);
    check("rst_data", bus.tx_st_data, 0);
    check("rst_cnt", bus.cpl_count, 0);
    check("rst_rdy", bus.resp_ready, 0);
    rst = 1'b0;
    #1;
    check("rel_rdy", bus.resp_ready, 1);

    // unaligned: data rides with DW2
    b0 = beats.size();
    send(16'h0008, 8'h05, 5'h01, 32'hDEADBEEF);
    wait_eops(1);
    check("u_nbeats", beats.size() - b0, 2);
    chk_beat("u_b0", b0, 64'h01000004_4A000001, 2'b10);
    chk_beat("u_b1", b0 + 1, 64'hDEADBEEF_00080504, 2'b01);
    check("u_lat", beats[b0].cyc - acc_cyc[acc_cyc.size()-1], 1);
    check("u_cnt", bus.cpl_count, 1);

    // aligned: padded third beat
    b0 = beats.size();
    send(16'h0008, 8'h05, 5'h02, 32'hDEADBEEF);
    wait_eops(2);
    check("a_nbeats", beats.size() - b0, 3);
    chk_beat("a_b0", b0, 64'h01000004_4A000001, 2'b10);
    chk_beat("a_b1", b0 + 1, 64'h00000000_00080508, 2'b00);
    chk_beat("a_b2", b0 + 2, 64'h00000000_DEADBEEF, 2'b01);
    check("a_cnt", bus.cpl_count, 2);

    // backpressure held in HDR1
    b0 = beats.size();
    send(16'h0008, 8'h05, 5'h02, 32'hDEADBEEF);
    @(negedge clk);
    bus.tx_st_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_data", bus.tx_st_data, 64'h00000000_00080508);
      check("bp_flags",
            {bus.tx_st_valid, bus.tx_st_sop, bus.tx_st_eop}, 3'b100);
      check("bp_rdy", bus.resp_ready, 0);
      check("bp_cnt", bus.cpl_count, 2);
    end
    check("bp_nbeats", beats.size() - b0, 1);
    bus.tx_st_ready = 1'b1;
    wait_eops(3);
    chk_beat("bp_b2", b0 + 2, 64'h00000000_DEADBEEF, 2'b01);
    check("bp_cnt_end", bus.cpl_count, 3);

    // back-to-back with valid held
    b0 = beats.size();
    es = acc_cyc.size();
    @(negedge clk);
    bus.resp_data  = pack(16'h0008, 8'h05, 5'h01, 32'hDEADBEEF);
    bus.resp_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cyc.size() < es + 2; i++)
      @(negedge clk);
    bus.resp_valid = 1'b0;
    check("b2b_accepts", acc_cyc.size(), es + 2);
    wait_eops(5);
    check("b2b_nbeats", beats.size() - b0, 4);
    chk_beat("b2b_b2", b0 + 2, 64'h01000004_4A000001, 2'b10);
    check("b2b_gap", beats[b0+2].cyc - beats[b0+1].cyc, 2);
    check("b2b_cnt", bus.cpl_count, 5);
    check("wrap_cnt", cnt2, 1);

    // reset while the pad beat is pending
    send(16'h0008, 8'h05, 5'h02, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    check("pad_eop_pre", bus.tx_st_eop, 1);
    bs = beats.size();
    es = eops;
    #1 rst = 1'b1;
    #1;
    check("mid_valid", bus.tx_st_valid, 0);
    check("mid_eop", bus.tx_st_eop, 0);
    check("mid_data", bus.tx_st_data, 0);
    check("mid_cnt", bus.cpl_count, 0);
    check("mid_cnt_w", cnt2, 0);
    check("mid_rdy", bus.resp_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_nbeats", beats.size(), bs);
    check("mid_eops", eops, es);

    // clean TLP after reset, new completer id sampled at accept
    b0 = beats.size();
    bus.completer_id = 16'h0203;
    send(16'hBEEF, 8'hA0, 5'h01, 32'h12345678);
    bus.completer_id = 16'hFFFF;
    wait_eops(es + 1);
    chk_beat("pr_b0", b0, 64'h02030004_4A000001, 2'b10);
    chk_beat("pr_b1", b0 + 1, 64'h12345678_BEEFA004, 2'b01);
    check("pr_cnt", bus.cpl_count, 1);
    check("pr_cnt_w", cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
